// File: rtl/operand_loader_pkg.sv
// loader_pkg: shared state type, widths and stage encodings for operand_loader
package loader_pkg;
    localparam int OPND_W = 6;
    localparam int OP_W = 3;
    typedef enum logic [1:0] {ENTER_A, ENTER_B, ENTER_OP, STROBE} loader_state_t;
    localparam logic [1:0] STAGE_A = 2'd0;
    localparam logic [1:0] STAGE_B = 2'd1;
    localparam logic [1:0] STAGE_OP = 2'd2;
    localparam logic [1:0] STAGE_STROBE = 2'd3;
    function automatic logic [1:0] stage_of(input loader_state_t s);
        return s == ENTER_A ? STAGE_A : s == ENTER_B ? STAGE_B : s == ENTER_OP ? STAGE_OP : STAGE_STROBE;
    endfunction
endpackage

// File: rtl/operand_loader_if.sv
// operand_loader_if: switch/button inputs and operand/strobe outputs of the loader
interface operand_loader_if;
    import loader_pkg::*;
    logic [OPND_W-1:0] sw;
    logic btn;
    logic [OPND_W-1:0] a;
    logic [OPND_W-1:0] b;
    logic [OP_W-1:0] op;
    logic set;
    logic [1:0] stage;
    logic busy;
    modport master(output sw, btn, input a, b, op, set, stage, busy);
    modport slave(input sw, btn, output a, b, op, set, stage, busy);
endinterface

// File: rtl/operand_loader_button.sv
// loader_button: 2-FF btn sync, debouncer when LOADER_DEBOUNCE_EN is defined, falling-edge press
module loader_button #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic iclk,
    input  logic rst,
    input  logic i_btn,
    output logic o_press
);
    logic [1:0] r_sync;
    logic r_prev;
    logic w_level;
    always_ff @(posedge iclk) begin
        if (rst) begin
            r_sync <= 2'b11;
            r_prev <= 1'b1;
        end else begin
            r_sync <= {r_sync[0], i_btn};
            r_prev <= w_level;
        end
    end
`ifdef LOADER_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    logic [CNT_W-1:0] r_cnt;
    logic r_level;
    always_ff @(posedge iclk) begin
        if (rst) begin
            r_cnt <= '0;
            r_level <= 1'b1;
        end else if (r_sync[1] == r_level) begin
            r_cnt <= '0;
        end else if (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            r_cnt <= '0;
            r_level <= r_sync[1];
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end
    assign w_level = r_level;
`else
    assign w_level = r_sync[1];
`endif
    assign o_press = r_prev & ~w_level;
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $error("DEBOUNCE_CYCLES must be at least 1");
    end
endmodule

// File: rtl/operand_loader.sv
// operand_loader: A/B/OP entry FSM with active-low set strobe; LOADER_DEBOUNCE_EN adds btn debounce
module operand_loader
    import loader_pkg::*;
#(
    parameter int SET_LOW_CYCLES = 4,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input logic iclk,
    input logic rst,
    operand_loader_if.slave bus
);
    localparam int CNT_W = $clog2(SET_LOW_CYCLES + 1);
    loader_state_t r_state, w_state;
    logic [OPND_W-1:0] r_a, r_b, w_a, w_b;
    logic [OP_W-1:0] r_op, w_op;
    logic [CNT_W-1:0] r_cnt, w_cnt;
    logic [1:0] r_stage;
    logic r_busy;
    logic w_press;
    loader_button #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_button (
        .iclk(iclk),
        .rst(rst),
        .i_btn(bus.btn),
        .o_press(w_press)
    );
    always_ff @(posedge iclk) begin
        if (rst) begin
            r_state <= ENTER_A;
            r_a <= '0;
            r_b <= '0;
            r_op <= '0;
            r_cnt <= '0;
            r_stage <= STAGE_A;
            r_busy <= 1'b0;
        end else begin
            r_state <= w_state;
            r_a <= w_a;
            r_b <= w_b;
            r_op <= w_op;
            r_cnt <= w_cnt;
            r_stage <= stage_of(w_state);
            r_busy <= w_state == STROBE;
        end
    end
    // presses arriving during STROBE fall through untouched and are lost
    always_comb begin
        w_state = r_state;
        w_a = r_a;
        w_b = r_b;
        w_op = r_op;
        w_cnt = r_cnt;
        if (r_state == STROBE) begin
            w_cnt = r_cnt - 1'b1;
            w_state = r_cnt == CNT_W'(1) ? ENTER_A : STROBE;
        end else if (w_press) begin
            w_a = r_state == ENTER_A ? bus.sw : r_a;
            w_b = r_state == ENTER_B ? bus.sw : r_b;
            w_op = r_state == ENTER_OP ? bus.sw[OP_W-1:0] : r_op;
            w_cnt = r_state == ENTER_OP ? CNT_W'(SET_LOW_CYCLES) : r_cnt;
            w_state = r_state == ENTER_A ? ENTER_B : r_state == ENTER_B ? ENTER_OP : STROBE;
        end
    end
    assign bus.a = r_a;
    assign bus.b = r_b;
    assign bus.op = r_op;
    assign bus.set = ~r_busy;
    assign bus.stage = r_stage;
    assign bus.busy = r_busy;
    if (SET_LOW_CYCLES < 3) begin : g_bad_set
        $error("SET_LOW_CYCLES must be at least 3");
    end
endmodule

// File: doc/operand_loader.md
# operand_loader

Front-end sequencer that drives the ALU operand/latch interface. The user enters operand A, operand B and an opcode in turn from six slide switches, each confirmed by a push button. The block then presents them on stable buses and issues an active-low `set` strobe. That strobe is what the downstream latch/display controller synchronizes and edge-detects to capture its inputs.

## Interface
Parameters:
- `SET_LOW_CYCLES`, 4: cycles `set` is held low per strobe; legal range ≥3, so the downstream 2-FF synchronizer always sees the falling edge.
- `DEBOUNCE_CYCLES`, 16: stable-level count required by the debouncer; used only when `LOADER_DEBOUNCE_EN` is defined.

Ports:
- `iclk` in 1: system clock; the single clock domain.
- `rst` in 1: reset; synchronous, active-high.
- `sw` in 6: raw switch value; 6-bit two's complement for operands, `sw[2:0]` for the opcode.
- `btn` in 1: raw confirm button, active-low (pressed = 0), asynchronous.
- `a` out 6: operand A.
- `b` out 6: operand B.
- `op` out 3: opcode.
- `set` out 1: latch strobe; idles high and falls to request capture.
- `stage` out 2: current entry step for LEDs; 0=A, 1=B, 2=OP, 3=strobing.
- `busy` out 1: high while the strobe is in progress.

## Operation
- `btn` passes through a 2-FF synchronizer (optionally followed by a debouncer) and a falling-edge detector, producing a one-cycle `press` event.
- FSM states: ENTER_A, ENTER_B, ENTER_OP, STROBE.
  - ENTER_A: on `press`, `a<=sw`, then go to ENTER_B.
  - ENTER_B: on `press`, `b<=sw`, then go to ENTER_OP.
  - ENTER_OP: on `press`, `op<=sw[2:0]`, load the strobe counter with SET_LOW_CYCLES, then go to STROBE.
  - STROBE: `set`=0 and `busy`=1. The counter decrements each cycle. When it reaches 0 in STROBE, drive `set`=1 and `busy`=0, then go to ENTER_A.
- `press` events in STROBE are discarded, not queued.
- `a`, `b` and `op` change only on their own capture. Between captures they hold, including through STROBE, so the downstream capture sees stable data.
- `sw` is sampled without synchronization. The value captured is `sw` at the clock edge where `press` is high.
- Reset (any state, including mid-STROBE) gives:
  - state ENTER_A;
  - `a`=0, `b`=0, `op`=0;
  - `set`=1, `busy`=0, `stage`=0;
  - synchronizer/debouncer flops at the released level (1), so no spurious `press` follows reset.

## Timing
- Without debounce, `btn` falling at the edge before cycle k gives `press` high at cycle k+2. The register is updated at the end of k+2 and visible from k+3.
- `set` is low for exactly SET_LOW_CYCLES consecutive cycles, starting the cycle after the ENTER_OP capture.
- `stage` and `busy` are registered and change in the same cycle as the state.
- Minimum press-to-press spacing for acceptance: 2 cycles (edge detector needs a release sample), plus debounce time when enabled.

## Configuration
- `LOADER_DEBOUNCE_EN` defined:
  - The synchronized button changes its filtered level only after DEBOUNCE_CYCLES consecutive identical samples.
  - Glitches shorter than that produce no `press`.
  - Press latency grows by DEBOUNCE_CYCLES.
- Undefined: no debouncer is instantiated, and every synchronized falling edge is a `press`.

## Structure
- Package `loader_pkg`:
  - state enum `loader_state_t`;
  - `OPND_W`=6, `OP_W`=3;
  - stage encoding constants.
- One sub-module, `loader_button`: synchronizer, optional debouncer and falling-edge detector. It outputs the single-cycle `press`.
- The top level holds the FSM, operand registers and strobe counter.

## Test plan
- After reset, press with `sw`=6'b000101, then 6'b111011, then 3'b010:
  - `a`=5, `b`=−5 (6'h3B), `op`=2;
  - `set` low exactly 4 cycles, then `stage` returns to 0.
- Press 3 times during STROBE: no register changes, and `stage` returns to 0 after the strobe.
- Assert `rst` in cycle 2 of STROBE: `set`=1, `busy`=0, all outputs 0 on the next cycle, and no extra `press`.
- Change `sw` every cycle around a press: the captured value equals `sw` at the `press` cycle.
- With `LOADER_DEBOUNCE_EN`: a 10-cycle low glitch gives no capture, while a 20-cycle low press captures once.
- SET_LOW_CYCLES=3 with back-to-back full sequences: each strobe is exactly 3 low cycles, and there is no capture loss at the STROBE→ENTER_A boundary.
